// File: rtl/ddr_refresh_sched.sv
// DDR refresh scheduler: accrues one refresh obligation per TREFI clocks, borrows the
// memory from the command scheduler via rfc_req/rfc_ack, and issues AUTO REFRESH with tRFC spacing.
module ddr_refresh_sched #(
  parameter int unsigned TREFI     = 1040,
  parameter int unsigned TRFC      = 10,
  parameter int unsigned MAX_DEBT  = 8,
  parameter int unsigned URGENT_AT = 6,
  parameter int unsigned CNT_WIDTH = 11
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  output logic       rfc_req_o,
  output logic       rfc_urgent_o,
  input  logic       rfc_ack_i,
  output logic       ref_cmd_o,
  output logic       rfc_end_o,
  output logic [3:0] debt_o,
  output logic       overflow_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_CMD  = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam int unsigned TW = $clog2(TRFC);
  localparam logic [CNT_WIDTH-1:0] RELOAD    = CNT_WIDTH'(TREFI - 1);
  localparam logic [TW-1:0]        TRFC_LOAD = TW'(TRFC - 1);
  localparam logic [3:0]           DEBT_MAX  = 4'(MAX_DEBT);
  localparam logic [3:0]           DEBT_URG  = 4'(URGENT_AT);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] interval;
  logic                 tick;
  logic [TW-1:0]        timer;
  logic [3:0]           debt_next;
  logic                 ovf_set;

  // Tick is registered, so the first one lands TREFI clocks after enable rises.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      interval <= RELOAD;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (enable_i) begin
        if (interval == '0) begin
          interval <= RELOAD;
          tick     <= 1'b1;
        end else begin
          interval <= interval - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    debt_next = debt_o;
    ovf_set   = 1'b0;
    if (tick && !ref_cmd_o) begin
      if (debt_o == DEBT_MAX) ovf_set = 1'b1;
      else                    debt_next = debt_o + 4'd1;
    end else if (!tick && ref_cmd_o) begin
      debt_next = debt_o - 4'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      timer        <= '0;
      rfc_req_o    <= 1'b0;
      ref_cmd_o    <= 1'b0;
      rfc_end_o    <= 1'b0;
      rfc_urgent_o <= 1'b0;
      debt_o       <= '0;
      overflow_o   <= 1'b0;
    end else begin
      debt_o       <= debt_next;
      rfc_urgent_o <= (debt_next >= DEBT_URG);
      if (ovf_set) overflow_o <= 1'b1;
      ref_cmd_o <= 1'b0;
      rfc_end_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (debt_o != '0) begin
            state     <= ST_REQ;
            rfc_req_o <= 1'b1;
          end
        end
        ST_REQ: begin
          if (rfc_ack_i) begin
            state     <= ST_CMD;
            ref_cmd_o <= 1'b1;
          end
        end
        ST_CMD: begin
          state <= ST_WAIT;
          timer <= TRFC_LOAD;
        end
        ST_WAIT: begin
          // debt_o here already reflects the decrement from the command just issued.
          if (timer == '0) begin
            if (debt_o != '0 && rfc_ack_i) begin
              state     <= ST_CMD;
              ref_cmd_o <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              rfc_req_o <= 1'b0;
              rfc_end_o <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_refresh_sched.sv
// Bench for ddr_refresh_sched: cycle-level reference model checked every clock,
// plus directed scenarios with hand-computed literal expectations.
module tb_ddr_refresh_sched;
  localparam int TREFI     = 16;
  localparam int TRFC      = 4;
  localparam int MAX_DEBT  = 8;
  localparam int URGENT_AT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       ack = 1'b0;
  logic       req, urg, cmd, rend, ovf;
  logic [3:0] debt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  ddr_refresh_sched #(
    .TREFI(TREFI), .TRFC(TRFC), .MAX_DEBT(MAX_DEBT), .URGENT_AT(URGENT_AT), .CNT_WIDTH(5)
  ) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en),
    .rfc_req_o(req), .rfc_urgent_o(urg), .rfc_ack_i(ack),
    .ref_cmd_o(cmd), .rfc_end_o(rend), .debt_o(debt), .overflow_o(ovf)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: debt is a plain counter of ticks minus commands; a refresh
  // session is tracked by the number of clocks elapsed since its last command.
  bit m_live = 0;
  int m_debt, en_edges, since;
  bit m_req, m_urg, m_cmd, m_end, m_ovf, m_tick;

  always @(posedge clk) begin : model
    int nd;
    bit nt, ncmd, nend, nreq;
    cyc++;
    if (rst) begin
      m_live = 1; m_debt = 0; en_edges = 0; since = -1;
      m_req = 0; m_urg = 0; m_cmd = 0; m_end = 0; m_ovf = 0; m_tick = 0;
    end else if (m_live) begin
      nt = 0;
      if (en) begin
        en_edges++;
        if (en_edges % TREFI == 0) nt = 1;
      end
      nd = m_debt + (m_tick ? 1 : 0) - (m_cmd ? 1 : 0);
      if (nd > MAX_DEBT) begin
        nd = MAX_DEBT;
        m_ovf = 1;
      end
      ncmd = 0; nend = 0; nreq = m_req;
      if (!m_req) begin
        if (m_debt != 0) begin nreq = 1; since = -1; end
      end else if (since < 0) begin
        if (ack) begin ncmd = 1; since = 0; end
      end else begin
        since++;
        if (since == TRFC + 1) begin
          if (m_debt != 0 && ack) begin ncmd = 1; since = 0; end
          else begin nreq = 0; nend = 1; end
        end
      end
      m_debt = nd; m_tick = nt; m_cmd = ncmd; m_end = nend; m_req = nreq;
      m_urg = (nd >= URGENT_AT);
    end
    #2;
    if (m_live) begin
      check("model_req",     32'(req),  32'(m_req));
      check("model_urgent",  32'(urg),  32'(m_urg));
      check("model_ref_cmd", 32'(cmd),  32'(m_cmd));
      check("model_end",     32'(rend), 32'(m_end));
      check("model_debt",    32'(debt), 32'(m_debt));
      check("model_ovf",     32'(ovf),  32'(m_ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; ack = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req"},  32'(req),  0);
    check({name, "_urg"},  32'(urg),  0);
    check({name, "_cmd"},  32'(cmd),  0);
    check({name, "_end"},  32'(rend), 0);
    check({name, "_debt"}, 32'(debt), 0);
    check({name, "_ovf"},  32'(ovf),  0);
  endtask

  int pulses, ends, last;

  initial begin
    // Reset state and basic cycle
    do_reset();
    check_all_zero("reset");
    en = 1'b1; ack = 1'b1;
    step(16); check("t1_debt_before_tick", 32'(debt), 0);
    step(1);  check("t1_debt_t17", 32'(debt), 1); check("t1_req_t17", 32'(req), 0);
    step(1);  check("t1_req_t18", 32'(req), 1);   check("t1_cmd_t18", 32'(cmd), 0);
    step(1);  check("t1_cmd_t19", 32'(cmd), 1);
    step(1);  check("t1_cmd_t20", 32'(cmd), 0);   check("t1_debt_t20", 32'(debt), 0);
    step(3);  check("t1_end_t23", 32'(rend), 0);  check("t1_req_t23", 32'(req), 1);
    step(1);  check("t1_end_t24", 32'(rend), 1);  check("t1_req_t24", 32'(req), 0);
    step(1);  check("t1_end_t25", 32'(rend), 0);

    // Postpone seven refreshes, then catch up back-to-back
    do_reset();
    en = 1'b1; ack = 1'b0;
    step(81); check("t2_debt5", 32'(debt), 5); check("t2_urg_at5", 32'(urg), 0);
    step(16); check("t2_debt6", 32'(debt), 6); check("t2_urg_at6", 32'(urg), 1);
    step(16); check("t2_debt7", 32'(debt), 7);
    en = 1'b0; ack = 1'b1;
    pulses = 0; ends = 0; last = -1;
    repeat (45) begin
      step(1);
      if (cmd) begin
        if (last >= 0) check("t2_cmd_spacing", 32'(cyc - last), 5);
        last = cyc;
        pulses++;
      end
      if (rend) begin
        ends++;
        check("t2_end_after_last_cmd", 32'(cyc - last), 5);
      end
    end
    check("t2_pulses", 32'(pulses), 7);
    check("t2_ends", 32'(ends), 1);
    check("t2_debt_drained", 32'(debt), 0);
    check("t2_urg_cleared", 32'(urg), 0);

    // Overflow is sticky
    do_reset();
    en = 1'b1; ack = 1'b0;
    step(129); check("t3_debt8", 32'(debt), 8); check("t3_ovf_pre", 32'(ovf), 0);
    step(16);  check("t3_debt_sat", 32'(debt), 8); check("t3_ovf_set", 32'(ovf), 1);
    en = 1'b0; ack = 1'b1;
    step(60);  check("t3_debt_drained", 32'(debt), 0); check("t3_ovf_sticky", 32'(ovf), 1);

    // Refresh command coincides with a tick at debt 2
    do_reset();
    en = 1'b1; ack = 1'b0;
    step(47); check("t4_debt2", 32'(debt), 2);
    ack = 1'b1;
    step(1);  check("t4_cmd", 32'(cmd), 1); check("t4_debt_at_cmd", 32'(debt), 2);
    step(1);  check("t4_debt_unchanged", 32'(debt), 2);
    ack = 1'b0;
    step(10);

    // Ack dropped during WAIT
    do_reset();
    en = 1'b1; ack = 1'b0;
    step(49); check("t5_debt3", 32'(debt), 3);
    en = 1'b0; ack = 1'b1;
    step(1);  check("t5_cmd", 32'(cmd), 1);
    step(1);  check("t5_debt2", 32'(debt), 2);
    ack = 1'b0;
    step(3);  check("t5_wait_req", 32'(req), 1); check("t5_wait_end", 32'(rend), 0);
    step(1);  check("t5_end", 32'(rend), 1); check("t5_end_req", 32'(req), 0);
    step(1);  check("t5_rereq", 32'(req), 1); check("t5_rereq_debt", 32'(debt), 2);
    check("t5_no_cmd", 32'(cmd), 0);

    // Reset mid-WAIT, then frozen interval counter
    do_reset();
    en = 1'b1; ack = 1'b1;
    step(21); check("t6_in_wait", 32'(req), 1);
    rst = 1'b1;
    step(1);  check_all_zero("t6_reset_mid_wait");
    rst = 1'b0; en = 1'b0; ack = 1'b0;
    step(100); check("t6_frozen_debt", 32'(debt), 0); check("t6_frozen_req", 32'(req), 0);
    en = 1'b1; step(10);
    en = 1'b0; step(50); check("t6_paused_debt", 32'(debt), 0);
    en = 1'b1; step(6); check("t6_resume_debt0", 32'(debt), 0);
    step(1);  check("t6_resume_debt1", 32'(debt), 1);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
